mem_access_ctrl: RTL
====================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, 16, max WAIT cycles before abort (legal range 2..255).
REQ-002 SHALL have port clk_i  in  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port MemRead_i  in  1  MEM-stage load request, from the EX/MEM ctrl bits.
REQ-005 SHALL have port MemWrite_i  in  1  MEM-stage store request, from the EX/MEM ctrl bits.
REQ-006 SHALL have port addr_i  in  32  MEM-stage ALU result (byte address).
REQ-007 SHALL have port wdata_i  in  32  MEM-stage store data (RS2 data).
REQ-008 SHALL have port mem_req_o  out  1  request to the multi-cycle data memory.
REQ-009 SHALL have port mem_we_o  out  1  1 = write, 0 = read; valid while mem_req_o is high.
REQ-010 SHALL have ports mem_addr_o / mem_wdata_o  out  32 each  latched address and write data.
REQ-011 SHALL have port mem_ack_i  in  1  single-cycle completion pulse from memory.
REQ-012 SHALL have port mem_rdata_i  in  32  read data, valid in the mem_ack_i cycle.
REQ-013 SHALL have port rdata_o  out  32  load result delivered to the MEM/WB path.
REQ-014 SHALL have port stall_o  out  1  freezes PC, IF/ID, ID/EX and EX/MEM (their Stall_i inputs).
REQ-015 SHALL have port err_o  out  1  sticky timeout flag.
REQ-016 SHALL have port stall_cnt_o  out  32  performance counter of stalled cycles.

Function
REQ-017 SHALL implement an FSM with three states: IDLE, WAIT and DONE.
REQ-018 IDLE: when MemRead_i or MemWrite_i is high, SHALL latch addr_i, wdata_i and we = MemWrite_i into mem_addr_o, mem_wdata_o and mem_we_o, then go to WAIT; otherwise it SHALL stay in IDLE.
REQ-019 If MemRead_i and MemWrite_i are both high, SHALL treat the access as a write; err_o SHALL NOT be affected.
REQ-020 WAIT: mem_req_o SHALL be 1 (registered; 0 in every other state), and address, data and we SHALL stay stable.
REQ-021 WAIT with mem_ack_i=1: SHALL latch mem_rdata_i into rdata_o (read access only; a write leaves rdata_o unchanged) and go to DONE.
REQ-022 DONE: SHALL last exactly one cycle, then return to IDLE; request inputs SHALL be ignored in DONE.
REQ-023 stall_o SHALL be combinational, equal to (state==IDLE and (MemRead_i or MemWrite_i)) or state==WAIT.
REQ-024 stall_o SHALL be 0 in DONE, so the pipeline advances exactly once per completed access.
REQ-025 Minimum latency: request seen in cycle N with ack in N+1 SHALL give stall_o high in N and N+1, DONE in N+2 and rdata_o valid from N+2.
REQ-026 A wait counter SHALL clear on entry to WAIT and increment each cycle in WAIT without ack.
REQ-027 When the wait counter reaches TIMEOUT-1 without ack, SHALL set err_o=1, drop mem_req_o, set rdata_o=0 and go to DONE.
REQ-028 An ack that coincides with the timeout cycle SHALL take priority: normal completion, err_o unchanged.
REQ-029 mem_ack_i SHALL be ignored in IDLE and DONE.
REQ-030 err_o SHALL remain 1 until reset.
REQ-031 stall_cnt_o SHALL increment by 1 on every rising edge where stall_o=1, and SHALL saturate at 32'hFFFF_FFFF (no wrap).

Reset
REQ-032 rst_i high SHALL immediately force: state IDLE; mem_req_o, mem_we_o, err_o = 0; mem_addr_o, mem_wdata_o, rdata_o, stall_cnt_o, wait counter = 0.
REQ-033 Reset asserted during WAIT SHALL drop mem_req_o without waiting for ack; a late ack after reset SHALL be ignored.
REQ-034 While rst_i is high, stall_o SHALL follow REQ-023 with state IDLE.

Verification
REQ-035 Load: MemRead_i=1, addr_i=0x100, ack 3 cycles later with rdata 0xDEADBEEF -> stall_o high 4 cycles, mem_we_o=0, rdata_o=0xDEADBEEF in DONE, stall_cnt_o=4.
REQ-036 Store: MemWrite_i=1, addr_i=0x20, wdata_i=0x12345678, immediate ack -> mem_we_o=1, mem_wdata_o=0x12345678, stall 2 cycles, rdata_o unchanged.
REQ-037 Back-to-back: load then store on consecutive instructions -> exactly one DONE cycle between them, two separate mem_req_o pulses, no duplicate access.
REQ-038 Timeout: TIMEOUT=4, no ack -> mem_req_o drops after 4 WAIT cycles, err_o=1 (sticky), rdata_o=0, FSM back to IDLE; ack in the final WAIT cycle -> err_o stays 0.
REQ-039 Reset mid-WAIT: rst_i pulsed 2 cycles into WAIT -> all outputs 0 immediately; a subsequent ack is ignored; the next load completes normally.
REQ-040 Saturation: stall_cnt_o preloaded to 0xFFFF_FFFE via force, 3 stall cycles -> stall_cnt_o = 0xFFFF_FFFF.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: hands a load/store to a multi-cycle data memory,
// stalls the front of the pipeline until it completes or times out.
module mem_access_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        err_o,
  output logic [31:0] stall_cnt_o
);

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic       access_req;
  logic       ack_hit;
  logic       timeout_hit;
  logic [7:0] wait_cnt;

  assign access_req  = MemRead_i | MemWrite_i;
  assign ack_hit     = (state == WAIT) && mem_ack_i;
  // An ack arriving in the last allowed cycle wins over the timeout.
  assign timeout_hit = (state == WAIT) && !mem_ack_i && (wait_cnt == LAST_WAIT);

  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    case (state)
      IDLE: begin
        stall_o = access_req;
        if (access_req) state_nxt = WAIT;
      end
      WAIT: begin
        stall_o = 1'b1;
        if (ack_hit || timeout_hit) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Request launch: address, data and direction are frozen for the whole access.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_addr_o  <= 32'd0;
      mem_wdata_o <= 32'd0;
      mem_we_o    <= 1'b0;
    end else if (state == IDLE && access_req) begin
      mem_addr_o  <= addr_i;
      mem_wdata_o <= wdata_i;
      mem_we_o    <= MemWrite_i;
    end
  end

  // Completion / timeout handling.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_req_o <= 1'b0;
      wait_cnt  <= 8'd0;
      rdata_o   <= 32'd0;
      err_o     <= 1'b0;
    end else begin
      if (state == IDLE && access_req) begin
        mem_req_o <= 1'b1;
        wait_cnt  <= 8'd0;
      end else if (ack_hit) begin
        mem_req_o <= 1'b0;
        if (!mem_we_o) rdata_o <= mem_rdata_i;
      end else if (timeout_hit) begin
        mem_req_o <= 1'b0;
        err_o     <= 1'b1;
        rdata_o   <= 32'd0;
      end else if (state == WAIT) begin
        wait_cnt  <= wait_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        stall_cnt_o <= 32'd0;
    else if (stall_o) stall_cnt_o <= sat_inc(stall_cnt_o);
  end

endmodule
